// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// decoder_pkg : shared widths and FSM state codes for the one-hot sequencer
// Rev 1.0
// ============================================================================
package decoder_pkg;

  localparam int IDX_W_DEF = 3;
  localparam int OUT_W_DEF = 1 << IDX_W_DEF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/idx_fifo.sv
`default_nettype none
// ============================================================================
// idx_fifo : DEPTH x W index FIFO, head word presented combinationally
// Rev 1.0
// ============================================================================
module idx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  // DEPTH is a power of two, so pointer wrap is plain overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/onehot_decoder_sequencer.sv
`default_nettype none
// ============================================================================
// onehot_decoder_sequencer : buffers indices, replays each as a one-hot word
// held for HOLD cycles. Rev 1.0
// ============================================================================
module onehot_decoder_sequencer
  import decoder_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int OUT_W = 1 << IDX_W,
  parameter int DEPTH = 4,
  parameter int HOLD  = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_onehot,
  output logic [CNT_W-1:0] fifo_cnt
);

  localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [0:0]        state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [OUT_W-1:0]  onehot_q, onehot_d;
  logic              valid_q, valid_d;
  logic              pop, push, full, empty;
  logic [IDX_W-1:0]  head;

  assign in_ready   = !full;
  assign push       = in_valid && !full && !clr;
  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;

  idx_fifo #(
    .DEPTH (DEPTH),
    .W     (IDX_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (in_idx),
    .rdata (head),
    .cnt   (fifo_cnt),
    .full  (full),
    .empty (empty)
  );

  // Reloading straight from DRIVE when the hold expires keeps words gapless
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    if (clr) begin
      state_d  = ST_IDLE;
      hcnt_d   = '0;
      onehot_d = '0;
      valid_d  = 1'b0;
    end else if ((state_q == ST_DRIVE) && (hcnt_q != '0)) begin
      hcnt_d = hcnt_q - HCNT_W'(1);
    end else if (!empty) begin
      pop      = 1'b1;
      onehot_d = OUT_W'(1) << head;
      valid_d  = 1'b1;
      hcnt_d   = HCNT_W'(HOLD - 1);
      state_d  = ST_DRIVE;
    end else begin
      state_d  = ST_IDLE;
      hcnt_d   = '0;
      onehot_d = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_sequencer.sv
`default_nettype none
// ============================================================================
// tb_onehot_decoder_sequencer : queue-based reference model, random + directed
// Rev 1.0
// ============================================================================
module tb_onehot_decoder_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, out_valid;
  logic [2:0] in_idx;
  logic [7:0] out_onehot;
  logic [2:0] fifo_cnt;

  int n_err    = 0;
  int n_checks = 0;

  // reference: queue of pending indices plus the word on the wire
  int mq[$];
  int cur = 0;
  int rem = 0;
  bit act = 0;

  bit seen5 = 0;
  bit saw_full = 0;
  int cnt_at_full = 0;

  always #5 clk = ~clk;

  onehot_decoder_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .fifo_cnt   (fifo_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit acc, input int idx, input bit c);
    if (c) begin
      mq.delete();
      act = 0;
      rem = 0;
    end else begin
      if (act && rem > 1) rem--;
      else if (mq.size() > 0) begin
        cur = mq.pop_front();
        rem = HOLD;
        act = 1;
      end else act = 0;
      if (acc) mq.push_back(idx);
    end
  endtask

  task automatic check_outputs();
    check("onehot", 32'(out_onehot), act ? (32'd1 << cur) : 32'd0);
    check("out_valid", 32'(out_valid), 32'(act));
    check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
    if (out_onehot == 8'h20) seen5 = 1;
  endtask

  // called at a negedge; drives inputs, steps the model across the posedge
  task automatic cycle(input bit v, input int idx, input bit c);
    bit acc;
    in_valid = v;
    in_idx   = 3'(idx);
    clr      = c;
    #1;
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (!in_ready && !saw_full) begin
      saw_full    = 1;
      cnt_at_full = int'(fifo_cnt);
    end
    acc = v && (mq.size() < DEPTH) && !c;
    @(posedge clk);
    model_step(acc, idx, c);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_idx = '0;
    #1;
    check("rst_onehot", 32'(out_onehot), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_cnt", 32'(fifo_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single index, latency one edge, exactly HOLD cycles
    cycle(1, 3, 0);
    check("single_lat", 32'(out_onehot), 32'h0);
    for (int i = 0; i < HOLD; i++) begin
      cycle(0, 0, 0);
      check("single_on", 32'(out_onehot), 32'h08);
    end
    cycle(0, 0, 0);
    check("single_off", 32'(out_onehot), 32'h0);
    idle(2);

    // back-to-back, no gap between words
    cycle(1, 6, 0);
    cycle(1, 0, 0);
    cycle(1, 7, 0);
    idle(3 * HOLD + 2);
    check("b2b_end", 32'(out_valid), 32'h0);

    // fill: one new index per cycle, refused ones dropped
    for (int k = 1; k <= 7; k++) cycle(1, k, 0);
    check("full_seen", 32'(saw_full), 32'h1);
    check("full_cnt", 32'(cnt_at_full), 32'(DEPTH));
    idle(8 * HOLD);

    // clr during DRIVE with two queued, simultaneous push of 5 dropped
    seen5 = 0;
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    cycle(1, 3, 0);
    check("clr_pre_cnt", 32'(fifo_cnt), 32'h2);
    cycle(1, 5, 1);
    check("clr_onehot", 32'(out_onehot), 32'h0);
    check("clr_cnt", 32'(fifo_cnt), 32'h0);
    idle(2 * HOLD);
    check("clr_no5", 32'(seen5), 32'h0);

    // async reset in cycle 2 of idx 4 with one entry queued
    cycle(1, 4, 0);
    cycle(1, 2, 0);
    cycle(0, 0, 0);
    check("ar_pre", 32'(out_onehot), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("ar_onehot", 32'(out_onehot), 32'h0);
    check("ar_valid", 32'(out_valid), 32'h0);
    check("ar_cnt", 32'(fifo_cnt), 32'h0);
    mq.delete();
    act = 0;
    rem = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ar_ready", 32'(in_ready), 32'h1);
    idle(2 * HOLD);
    check("ar_quiet", 32'(out_valid), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)),
            ($urandom_range(0, 49) == 0));
    end
    idle(6 * HOLD);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
